encrypt_mask_add_seq: RTL and testbench

//  Parametrised successor of the masked-add encryptor. Builds a key-derived mask,

---
 rtl/encrypt_mask_add_seq.sv | 159 +++++++++++++++
 tb/tb_encrypt_mask_add_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_mask_add_seq.sv
// Masked-add encryptor: key-derived mask added to plaintext by a chunked serial adder,
// ciphertext {key, sum, tag}. Define ENC_STATS_EN to add the enc_count handshake counter.
module encrypt_mask_add_seq #(
    parameter int unsigned DATA_W  = 60,
    parameter int unsigned KEY_W   = 11,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned CHUNK_W = 12
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [KEY_W-1:0]                in_key,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [KEY_W+DATA_W+TAG_W:0]     out_data
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]                     enc_count
`endif
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUM_W  = DATA_W - CHUNK_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                        state_q, state_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [DATA_W-1:0]             mask_q, mask_d;
    logic [KEY_W-1:0]              key_q, key_d;
    logic [TAG_W-1:0]              tag_q, tag_d;
    logic [SUM_W-1:0]              sum_q, sum_d;
    logic                          carry_q, carry_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          out_valid_q, out_valid_d;
    logic [KEY_W+DATA_W+TAG_W:0]   out_data_q, out_data_d;

    logic                          accept;
    logic                          last_chunk;
    logic [CHUNK_W:0]              chunk_sum;

    function automatic logic [DATA_W-1:0] make_mask(input logic [KEY_W-1:0] key);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            m[i] = key[i % KEY_W] ^ (((i / KEY_W) % 4) >= 2);
        end
        return m;
    endfunction

    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
    assign chunk_sum  = {1'b0, data_q[CHUNK_W-1:0]} + {1'b0, mask_q[CHUNK_W-1:0]}
                      + {{CHUNK_W{1'b0}}, carry_q};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            key_q       <= '0;
            tag_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            key_q       <= key_d;
            tag_q       <= tag_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operands shift down one chunk per cycle; completed sum chunks enter sum_q from the
    // top, so after the last chunk {chunk_sum, sum_q} is the full DATA_W+1 bit result.
    always_comb begin
        data_d      = data_q;
        mask_d      = mask_q;
        key_d       = key_q;
        tag_d       = tag_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    mask_d  = make_mask(in_key);
                    key_d   = in_key;
                    tag_d   = in_tag;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                data_d  = data_q >> CHUNK_W;
                mask_d  = mask_q >> CHUNK_W;
                sum_d   = SUM_W'({chunk_sum[CHUNK_W-1:0], sum_q} >> CHUNK_W);
                carry_d = chunk_sum[CHUNK_W];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_chunk) begin
                    out_data_d  = {key_q, chunk_sum, sum_q, tag_q};
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !Rst;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

`ifdef ENC_STATS_EN
    logic [15:0] enc_count_q, enc_count_d;

    always_comb begin
        enc_count_d = enc_count_q;
        if (out_valid_q && out_ready) enc_count_d = enc_count_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) enc_count_q <= '0;
        else     enc_count_q <= enc_count_d;
    end

    assign enc_count = enc_count_q;
`endif

endmodule

// File: tb/tb_encrypt_mask_add_seq.sv
// Self-checking bench for encrypt_mask_add_seq: transaction-level reference model plus
// literal ciphertext vectors; enc_count checks compiled in with ENC_STATS_EN.
`timescale 1ns/1ps
module tb_encrypt_mask_add_seq;

    localparam int DATA_W = 60;
    localparam int KEY_W  = 11;
    localparam int TAG_W  = 6;
    localparam int NCHUNK = 5;
    localparam int OUT_W  = KEY_W + DATA_W + 1 + TAG_W;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEY_W-1:0]  in_key = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
`ifdef ENC_STATS_EN
    logic [15:0]       enc_count;
`endif

    encrypt_mask_add_seq #(.DATA_W(DATA_W), .KEY_W(KEY_W), .TAG_W(TAG_W), .CHUNK_W(12)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ENC_STATS_EN
        , .enc_count(enc_count)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ciphertext straight from the rules: whole-key mask slices, one wide addition.
    function automatic logic [OUT_W-1:0] ref_ct(input logic [DATA_W-1:0] d,
                                                input logic [KEY_W-1:0] k,
                                                input logic [TAG_W-1:0] t);
        logic [71:0]       mask;
        logic [KEY_W-1:0]  s;
        logic [DATA_W:0]   sum;
        mask = '0;
        for (int j = 0; j * KEY_W < DATA_W; j++) begin
            s = ((j % 4) < 2) ? k : ~k;
            mask = mask | (72'(s) << (j * KEY_W));
        end
        sum = {1'b0, d} + {1'b0, mask[DATA_W-1:0]};
        return {k, sum, t};
    endfunction

    // Transaction timing model: idle / working for NCHUNK edges / presenting.
    int               m_phase = 0;
    int               m_left  = 0;
    logic             m_valid = 1'b0;
    logic [OUT_W-1:0] m_data  = '0;
    logic [OUT_W-1:0] m_pend  = '0;
    logic [15:0]      m_count = '0;
    int               cyc = 0;
    int               acc_q[$];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Rst) begin
            m_phase <= 0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= ref_ct(in_data, in_key, in_tag);
                    m_left  <= NCHUNK;
                    m_phase <= 1;
                    acc_q.push_back(cyc);
                end
                1: if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_data  <= m_pend;
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) begin
                    m_valid <= 1'b0;
                    m_phase <= 0;
                    m_count <= m_count + 16'd1;
                end
            endcase
        end
    end

    always @(negedge Clk) begin
        check("in_ready", in_ready, (m_phase == 0) && !Rst);
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("out_data", out_data, m_data);
`ifdef ENC_STATS_EN
        check("enc_count", enc_count, m_count);
`endif
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic [KEY_W-1:0] k,
                        input logic [TAG_W-1:0] t);
        int n = 0;
        @(negedge Clk);
        while (!in_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1'b0, 1'b1);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_tag   = t;
        @(posedge Clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until out_valid is seen; ends on a negedge.
    task automatic wait_valid(output int lat);
        lat = 0;
        forever begin
            @(negedge Clk);
            if (out_valid || lat >= 50) break;
            @(posedge Clk);
            lat++;
        end
        if (!out_valid) check("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b0);
        #1 Rst = 1'b0;
    endtask

    initial begin
        int                lat;
        logic [OUT_W-1:0]  exp;
        logic              saw_valid;
        logic [DATA_W-1:0] d;
        logic [KEY_W-1:0]  k;
        logic [TAG_W-1:0]  t;

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        check("reset_in_ready", in_ready, 1'b0);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("idle_in_ready", in_ready, 1'b1);

        // all-zero vector
        send('0, '0, '0);
        wait_valid(lat);
        check("t1_latency", lat, NCHUNK);
        check("t1_data", out_data, {11'h0, 61'h0_0000_0FFF_FFC0_0000, 6'h0});

        // all-ones data: carry-out lands in the sum MSB
        send(60'hFFF_FFFF_FFFF_FFFF, 11'h7FF, 6'h2A);
        wait_valid(lat);
        check("t2_latency", lat, NCHUNK);
        check("t2_data", out_data, {11'h7FF, 61'h1FFF_F000_003F_FFFE, 6'h2A});

        // backpressure with a busy, changing input side
        @(negedge Clk);
        #1 out_ready = 1'b0;
        d = {$urandom, $urandom};
        k = 11'($urandom);
        t = 6'($urandom);
        exp = ref_ct(d, k, t);
        send(d, k, t);
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            #1;
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_key   = 11'($urandom);
            in_tag   = 6'($urandom);
            @(negedge Clk);
            check("t3_hold_data", out_data, exp);
            check("t3_hold_valid", out_valid, 1'b1);
            check("t3_in_ready", in_ready, 1'b0);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        check("t3_release_in_ready", in_ready, 1'b1);
        check("t3_release_valid", out_valid, 1'b0);

        // continuous in_valid: one block per NCHUNK+2 edges
        acc_q.delete();
        for (int i = 0; i < 60 && acc_q.size() < 3; i++) begin
            #1;
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_key   = 11'($urandom);
            in_tag   = 6'($urandom);
            @(negedge Clk);
        end
        #1 in_valid = 1'b0;
        if (acc_q.size() >= 3) begin
            check("t4_spacing_1", acc_q[1] - acc_q[0], NCHUNK + 2);
            check("t4_spacing_2", acc_q[2] - acc_q[1], NCHUNK + 2);
        end else begin
            check("t4_accepts", acc_q.size(), 3);
        end
        repeat (10) @(negedge Clk);

        // reset in the middle of BUSY discards the block
        send({$urandom, $urandom}, 11'($urandom), 6'($urandom));
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            saw_valid = saw_valid | out_valid;
        end
        check("t5_no_output", saw_valid, 1'b0);
        d = {$urandom, $urandom};
        k = 11'($urandom);
        t = 6'($urandom);
        send(d, k, t);
        wait_valid(lat);
        check("t5_latency", lat, NCHUNK);
        check("t5_data", out_data, ref_ct(d, k, t));

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            in_key    = 11'($urandom);
            in_tag    = 6'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge Clk);

`ifdef ENC_STATS_EN
        pulse_reset();
        check("t6_cleared", enc_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom}, 11'($urandom), 6'($urandom));
            wait_valid(lat);
        end
        repeat (3) @(negedge Clk);
        check("t6_count3", enc_count, 16'd3);
        pulse_reset();
        check("t6_reset", enc_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
